// File: rtl/clk_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
// The optional tick output is enabled by defining CLK_DIVIDER_TICK_EN.
package clk_divider_pkg;

    // Default width of the ratio input and the period counter.
    localparam int CLK_DIV_WIDTH = 32;

    // Smallest ratio the divider produces; requests below this are clamped up.
    localparam int CLK_DIV_MIN = 2;

    // Ratio type at the default width.
    typedef logic [CLK_DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/clk_divider_counter.sv
// Period counter for clk_divider: counts 0 .. n_q-1 and wraps, latching the
// requested ratio only at the wrap so a ratio change never cuts a period short.
module clk_divider_counter
    import clk_divider_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_,
    input  logic [WIDTH-1:0] div_factor,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] n_q,
    output logic             wrap
);

    // Clamp the requested ratio so 0 and 1 behave as divide-by-2.
    function automatic logic [WIDTH-1:0] clamp_ratio(input logic [WIDTH-1:0] n);
        if (n < WIDTH'(CLK_DIV_MIN)) begin
            return WIDTH'(CLK_DIV_MIN);
        end
        return n;
    endfunction

    // Greater-or-equal rather than equality so an out-of-range count still wraps.
    assign wrap = (cnt >= (n_q - WIDTH'(1)));

    // Advance the counter; on wrap restart at 0 and pick up the new ratio.
    always_ff @(posedge clk_in) begin
        if (rst_) begin
            cnt <= '0;
            n_q <= clamp_ratio(div_factor);
        end else if (wrap) begin
            cnt <= '0;
            n_q <= clamp_ratio(div_factor);
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_divider.sv
// Programmable integer clock divider producing a registered square wave.
// High for floor(N/2) source cycles, low for the rest, N = max(div_factor, 2).
// Define CLK_DIVIDER_TICK_EN to add a one-cycle tick at every period start.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_,
    input  logic [WIDTH-1:0] div_factor,
    output logic             clk_out
`ifdef CLK_DIVIDER_TICK_EN
    ,
    output logic             tick
`endif
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_q;
    logic             wrap;
    logic [WIDTH-1:0] half_q;

    clk_divider_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk_in    (clk_in),
        .rst_      (rst_),
        .div_factor(div_factor),
        .cnt       (cnt),
        .n_q       (n_q),
        .wrap      (wrap)
    );

    // Length of the high phase for the period currently running.
    assign half_q = n_q >> 1;

    // Drive high for the first half_q counts; the wrap count is always low.
    always_ff @(posedge clk_in) begin
        if (rst_) begin
            clk_out <= 1'b0;
        end else begin
            clk_out <= !wrap && (cnt < half_q);
        end
    end

`ifdef CLK_DIVIDER_TICK_EN
    // Pulse once per period, aligned with the rising edge of clk_out.
    always_ff @(posedge clk_in) begin
        if (rst_) begin
            tick <= 1'b0;
        end else begin
            tick <= (cnt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed patterns plus a queue-based
// reference that expands each period into its list of expected output levels.
module tb_clk_divider;

    localparam int HALF_T = 5;

    logic        clk_in = 1'b0;
    logic        rst_;
    logic [31:0] div_factor;
    logic        clk_out;
`ifdef CLK_DIVIDER_TICK_EN
    logic        tick;
    logic        tick_mid;
    logic        tick_slow;
`endif

    logic        rst_pair;
    logic [31:0] div_mid;
    logic [31:0] div_slow;
    logic        mid_out;
    logic        slow_out;

    int checks = 0;
    int errors = 0;

    always #HALF_T clk_in = ~clk_in;

    clk_divider dut (
        .clk_in    (clk_in),
        .rst_      (rst_),
        .div_factor(div_factor),
        .clk_out   (clk_out)
`ifdef CLK_DIVIDER_TICK_EN
        ,
        .tick      (tick)
`endif
    );

    clk_divider dut_mid (
        .clk_in    (clk_in),
        .rst_      (rst_pair),
        .div_factor(div_mid),
        .clk_out   (mid_out)
`ifdef CLK_DIVIDER_TICK_EN
        ,
        .tick      (tick_mid)
`endif
    );

    clk_divider dut_slow (
        .clk_in    (clk_in),
        .rst_      (rst_pair),
        .div_factor(div_slow),
        .clk_out   (slow_out)
`ifdef CLK_DIVIDER_TICK_EN
        ,
        .tick      (tick_slow)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each period is a list of (start, level) entries; one entry per edge.
    logic [1:0] exp_q[$];
    logic       exp_out  = 1'b0;
    logic       exp_tick = 1'b0;
    bit         model_on = 1'b0;

    function automatic void fill_period(input logic [31:0] n);
        longint ne;
        ne = longint'(n);
        if (ne < 2) ne = 2;
        for (longint k = 0; k < ne; k++) begin
            exp_q.push_back({(k == 0) ? 1'b1 : 1'b0, (k < ne / 2) ? 1'b1 : 1'b0});
        end
    endfunction

    always @(posedge clk_in) begin
        logic [1:0] e;
        if (rst_ === 1'b1) begin
            exp_q.delete();
            fill_period(div_factor);
            exp_out  <= 1'b0;
            exp_tick <= 1'b0;
            model_on <= 1'b1;
        end else if (model_on) begin
            e = exp_q.pop_front();
            exp_out  <= e[0];
            exp_tick <= e[1];
            if (exp_q.size() == 0) fill_period(div_factor);
        end
    end

    always @(negedge clk_in) begin
        if (model_on) begin
            check("model_clk_out", {63'd0, clk_out}, {63'd0, exp_out});
`ifdef CLK_DIVIDER_TICK_EN
            check("model_tick", {63'd0, tick}, {63'd0, exp_tick});
`endif
        end
    end

    // Time between the two most recent rising edges of the main output.
    time last_rise  = 0;
    time rise_period = 0;
    always @(posedge clk_out) begin
        rise_period = $time - last_rise;
        last_rise   = $time;
    end

    task automatic start(input logic [31:0] n, input int cyc);
        @(negedge clk_in);
        rst_       = 1'b1;
        div_factor = n;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk_in);
            check("rst_clk_out", {63'd0, clk_out}, 64'd0);
`ifdef CLK_DIVIDER_TICK_EN
            check("rst_tick", {63'd0, tick}, 64'd0);
`endif
        end
        rst_ = 1'b0;
    endtask

    // Check one edge per character: '1' high, anything else low.
    task automatic expect_str(input string name, input string pat, input string tpat);
        for (int i = 0; i < pat.len(); i++) begin
            logic b;
            logic t;
            b = (pat[i] == 8'h31);
            t = (tpat[i] == 8'h31);
            @(negedge clk_in);
            check(name, {63'd0, clk_out}, {63'd0, b});
            check({name, "_model"}, {63'd0, exp_out}, {63'd0, b});
            check({name, "_model_tick"}, {63'd0, exp_tick}, {63'd0, t});
`ifdef CLK_DIVIDER_TICK_EN
            check({name, "_tick"}, {63'd0, tick}, {63'd0, t});
`endif
        end
    endtask

    initial begin
        int  mid_rises, mid_high, slow_high, slow_fall, run;
        int  min_hi, max_hi, min_lo, max_lo;
        logic mid_prev, slow_prev, run_val;
        time mid_rise1, mid_rise2;

        rst_       = 1'b1;
        div_factor = 32'd4;
        rst_pair   = 1'b1;
        div_mid    = 32'd1000;
        div_slow   = 32'd100000;

        // Divide by 4 from reset.
        start(32'd4, 2);
        expect_str("n4", "110011001", "100010001");

        // Divide by 5: 2 high, 3 low, 5-cycle period.
        start(32'd5, 2);
        expect_str("n5", "1100011000", "1000010000");
        check("n5_period", 64'(rise_period), 64'(5 * 2 * HALF_T));

        // Ratios 0 and 1 act as divide by 2.
        start(32'd0, 1);
        expect_str("n0", "101010", "101010");
        start(32'd1, 1);
        expect_str("n1", "101010", "101010");

        // Ratio 4 -> 6 mid-period: current period finishes, then 3/3.
        start(32'd4, 1);
        expect_str("chg_a", "1", "1");
        div_factor = 32'd6;
        expect_str("chg_b", "1001110001", "0001000001");

        // Reset during the high phase, new ratio applied on the reset edge.
        start(32'd6, 1);
        expect_str("rmid_a", "11", "10");
        rst_       = 1'b1;
        div_factor = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("rmid_rst_clk_out", {63'd0, clk_out}, 64'd0);
        end
        rst_ = 1'b0;
        expect_str("rmid_b", "11001100", "10001000");

        // Divide by 1000 and 100000 side by side on a shared reset.
        @(negedge clk_in);
        check("pair_rst_mid", {63'd0, mid_out}, 64'd0);
        check("pair_rst_slow", {63'd0, slow_out}, 64'd0);
        rst_pair  = 1'b0;
        mid_rises = 0;
        mid_high  = 0;
        slow_high = 0;
        slow_fall = 0;
        mid_prev  = 1'b0;
        slow_prev = 1'b0;
        run       = 0;
        run_val   = 1'b0;
        min_hi    = 1 << 30;
        max_hi    = 0;
        min_lo    = 1 << 30;
        max_lo    = 0;
        mid_rise1 = 0;
        mid_rise2 = 0;
        for (int i = 1; i <= 50001; i++) begin
            @(negedge clk_in);
            if (mid_out && !mid_prev) begin
                mid_rises++;
                if (mid_rises == 1) mid_rise1 = $time;
                if (mid_rises == 2) mid_rise2 = $time;
            end
            if (mid_out) mid_high++;
            if (slow_out) slow_high++;
            if (!slow_out && slow_prev && slow_fall == 0) slow_fall = i;
            if (i == 1) begin
                run_val = mid_out;
                run     = 1;
            end else if (mid_out == run_val) begin
                run++;
            end else begin
                if (run_val) begin
                    if (run < min_hi) min_hi = run;
                    if (run > max_hi) max_hi = run;
                end else begin
                    if (run < min_lo) min_lo = run;
                    if (run > max_lo) max_lo = run;
                end
                run_val = mid_out;
                run     = 1;
            end
            mid_prev  = mid_out;
            slow_prev = slow_out;
        end
        check("mid_rises", 64'(mid_rises), 64'd51);
        check("mid_high_total", 64'(mid_high), 64'd25001);
        check("mid_min_high", 64'(min_hi), 64'd500);
        check("mid_max_high", 64'(max_hi), 64'd500);
        check("mid_min_low", 64'(min_lo), 64'd500);
        check("mid_max_low", 64'(max_lo), 64'd500);
        check("mid_period", 64'(mid_rise2 - mid_rise1), 64'(1000 * 2 * HALF_T));
        check("slow_high_total", 64'(slow_high), 64'd50000);
        check("slow_fall_edge", 64'(slow_fall), 64'd50001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider.md
# clk_divider

Programmable integer clock divider. Derives a square-wave `clk_out` from `clk_in`, with the ratio set at run time by `div_factor`. Typical use is 100 MHz → 100 kHz (`div_factor` = 1000) and 100 MHz → 1 kHz (`div_factor` = 100000) for the scan and debounce timing domains. Several instances may share one clock and reset.

## Interface

Parameters:
- `WIDTH`, default 32: width of `div_factor` and of the internal counter. Must be ≥ 17 so that 100000 fits.

Ports:
- `clk_in`, in, 1: source clock. Every register updates on its rising edge.
- `rst_`, in, 1: reset. One clock; reset is synchronous and active-high. `rst_` = 1 at a `clk_in` rising edge resets the block.
- `div_factor`, in, `WIDTH`: requested division ratio N, unsigned.
- `clk_out`, out, 1: divided clock, registered (never combinational).
- `tick`, out, 1: present only with `CLK_DIVIDER_TICK_EN`.

## Operation

- Effective ratio: `n_eff` = max(`div_factor`, 2). Values 0, 1 and 2 all divide by 2.
- `half` = `n_eff` >> 1.
- State:
  - `cnt` (`WIDTH` bits): counts 0 .. `n_eff`−1, then wraps to 0.
  - `n_q`: latched `n_eff`.
- Reset edge:
  - `cnt` ← 0, `clk_out` ← 0.
  - `n_q` ← `n_eff` of the current `div_factor`.
  - `tick` ← 0.
- Non-reset edge:
  - `clk_out` ← (`cnt` < `half_q`), where `half_q` = `n_q` >> 1.
  - If `cnt` ≥ `n_q`−1: `cnt` ← 0 and `n_q` ← the current `n_eff` (period boundary).
  - Otherwise: `cnt` ← `cnt` + 1.
- Duty cycle:
  - Even N: exactly 50 %.
  - Odd N: high for floor(N/2) cycles, low for ceil(N/2) cycles.
- Changes to `div_factor` take effect only at a period boundary, so there are no runt pulses.
- The ≥ comparison guarantees wrap even if `cnt` somehow exceeds `n_q`−1.
- Counter arithmetic is unsigned, `WIDTH` bits wide, with no overflow because `cnt` < `n_q` ≤ 2^`WIDTH`−1.

## Timing

- `clk_out` reads 0 throughout reset.
- On the first non-reset edge, `clk_out` rises. It stays high for `half` edges, then low for `n_eff`−`half` edges, then repeats with period `n_eff` × T(`clk_in`).
- Latency from reset release to the first `clk_out` rise is one `clk_in` edge.
- Reset asserted mid-period: `clk_out` = 0 from the next edge, and the counter restarts from 0.
- Reset and a new `div_factor` on the same edge: the new value is used immediately after reset.

## Configuration

- `CLK_DIVIDER_TICK_EN` defined:
  - Adds output `tick` (1 bit, registered).
  - `tick` = 1 for exactly one `clk_in` cycle on the edge where `cnt` wraps to 0, once per period, coincident with the `clk_out` rising edge.
  - Reset value 0.
  - Intended as a clock-enable for logic that stays in the `clk_in` domain.
- Not defined: the `tick` port and its logic are absent. `clk_out` behaviour is identical in both builds.

## Structure

- Shared package `clk_divider_pkg`:
  - `CLK_DIV_WIDTH` = 32 (default for `WIDTH`).
  - `CLK_DIV_MIN` = 2.
  - `div_t` = logic [`CLK_DIV_WIDTH`−1:0].
- One sub-module, `clk_divider_counter`:
  - Contains the wrap counter with its ≥ wrap compare and the `n_q` latch.
  - Exposes `cnt`, `n_q` and `wrap`.
- The top level derives `clk_out` and `tick` from these signals.

## Test plan

- N=4, reset released: `clk_out` pattern after release is 1,1,0,0,1,1,0,0. With the tick feature, `tick` = 1 on edges 1, 5, 9.
- N=5: high for 2 cycles, low for 3, period 50 ns at 100 MHz.
- N=1000 and N=100000 at 100 MHz, run together: `clk_out` periods are 10 µs and 1 ms, both with 50 % duty.
- N=0 and N=1: both behave as divide-by-2 (alternating 1,0).
- N changed from 4 to 6 mid-period: the current 4-cycle period completes, then the output is 3 high / 3 low with no short pulse.
- Reset asserted mid-high-phase for 3 cycles: `clk_out` = 0 during reset, then rises on the first edge after release.
